// File: rtl/sig_debounce_pkg.sv
// Shared types and constants for the sig_debounce conditioning stage.
package sig_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned GLITCH_CNT_W   = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'd255;

  // Saturating increment for the glitch counter.
  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
    return (v == GLITCH_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sig_debounce_if.sv
// Level-in / debounced-level-out bundle; master drives the raw level, slave is the debouncer.
interface sig_debounce_if;
  import sig_debounce_pkg::*;

  logic                    sig_in;
  logic                    sig_out;
  logic                    busy;
  logic                    glitch;
  logic [GLITCH_CNT_W-1:0] glitch_cnt;

  modport master (output sig_in, input sig_out, busy, glitch, glitch_cnt);
  modport slave  (input sig_in, output sig_out, busy, glitch, glitch_cnt);
endinterface

// File: rtl/sig_sync.sv
// N-flop level synchronizer, async active-high reset to 0.
module sig_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/sig_debounce.sv
// Debounces a raw level into a clean clk-synchronous level and reports abandoned candidates.
// Build option SIG_DEBOUNCE_SYNC_EN inserts a SYNC_STAGES-flop synchronizer ahead of the FSM.
module sig_debounce
  import sig_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  sig_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sig_debounce: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("sig_debounce: STABLE_CYCLES must be >= 2");
  end

  logic w_s;

`ifdef SIG_DEBOUNCE_SYNC_EN
  sig_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.sig_in),
    .o_q (w_s)
  );
`else
  assign w_s = bus.sig_in;
`endif

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_out;
  logic                    r_busy;
  logic                    r_glitch;
  logic [GLITCH_CNT_W-1:0] r_gcnt;

  // Qualification FSM; busy tracks whether the next state is a CHK state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE_LO;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_glitch <= 1'b0;
      r_gcnt   <= '0;
    end else begin
      r_glitch <= 1'b0;
      case (r_state)
        IDLE_LO: if (w_s) begin
          r_state <= CHK_HI;
          r_cnt   <= CNT_W'(1);
          r_busy  <= 1'b1;
        end
        CHK_HI: if (!w_s) begin
          r_state  <= IDLE_LO;
          r_cnt    <= '0;
          r_busy   <= 1'b0;
          r_glitch <= 1'b1;
          r_gcnt   <= sat_inc(r_gcnt);
        end else if (r_cnt == CNT_LAST) begin
          r_state <= IDLE_HI;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_out   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        IDLE_HI: if (!w_s) begin
          r_state <= CHK_LO;
          r_cnt   <= CNT_W'(1);
          r_busy  <= 1'b1;
        end
        CHK_LO: if (w_s) begin
          r_state  <= IDLE_HI;
          r_cnt    <= '0;
          r_busy   <= 1'b0;
          r_glitch <= 1'b1;
          r_gcnt   <= sat_inc(r_gcnt);
        end else if (r_cnt == CNT_LAST) begin
          r_state <= IDLE_LO;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_out   <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_state <= IDLE_LO;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sig_out    = r_out;
  assign bus.busy       = r_busy;
  assign bus.glitch     = r_glitch;
  assign bus.glitch_cnt = r_gcnt;

endmodule

// File: tb/tb_sig_debounce.sv
// Self-checking bench for sig_debounce with a run-length reference model of the debounce rules.
module tb_sig_debounce;

  localparam int unsigned SC   = 4;
  localparam int unsigned SYNC = 2;
`ifdef SIG_DEBOUNCE_SYNC_EN
  localparam int unsigned LAT = SYNC;
`else
  localparam int unsigned LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sig_debounce_if bus ();

  sig_debounce #(.SYNC_STAGES(SYNC), .CNT_W(16), .STABLE_CYCLES(SC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: delay line for the synchronizer, then a run length of disagreeing samples.
  logic m_pipe[$];
  logic m_out;
  int   m_run;
  logic m_glitch;
  int   m_gcnt;

  function automatic void model_reset();
    m_pipe.delete();
    for (int i = 0; i < int'(LAT); i++) m_pipe.push_back(1'b0);
    m_out = 1'b0; m_run = 0; m_glitch = 1'b0; m_gcnt = 0;
  endfunction

  function automatic void model_step(input logic v);
    logic s;
    if (LAT == 0) s = v;
    else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(v);
    end
    m_glitch = 1'b0;
    if (s != m_out) begin
      m_run++;
      if (m_run == int'(SC)) begin m_out = ~m_out; m_run = 0; end
    end else if (m_run > 0) begin
      m_glitch = 1'b1;
      if (m_gcnt < 255) m_gcnt++;
      m_run = 0;
    end
  endfunction

  // Drive a level for one clock, advance the model at the edge, return at the next falling edge.
  task automatic tick(input logic v);
    bus.sig_in = v;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int rise_at = -1;
    rst = 1'b1; bus.sig_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (bus.sig_out !== 1'b0) begin n_fail++; $display("FAIL reset_sig_out got %b exp 0", bus.sig_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    if (bus.glitch !== 1'b0) begin n_fail++; $display("FAIL reset_glitch got %b exp 0", bus.glitch); end
    if (bus.glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_glitch_cnt got %0d exp 0", bus.glitch_cnt); end
    rst = 1'b0;
    for (int i = 1; i <= int'(LAT + SC) + 2; i++) begin
      tick(1'b1);
      if (rise_at < 0 && bus.sig_out === 1'b1) rise_at = i;
      n_checks++;
      if (bus.sig_out !== (i >= int'(LAT + SC))) begin
        n_fail++; $display("FAIL reset_release_sig_out edge %0d got %b exp %b", i, bus.sig_out, i >= int'(LAT + SC));
      end
    end
    n_checks++;
    if (rise_at != int'(LAT + SC)) begin n_fail++; $display("FAIL reset_rise_latency got %0d exp %0d", rise_at, LAT + SC); end
  endtask

  task automatic test_bounce_fall();
    logic pat[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int base = m_gcnt;
    int fall_at = -1;
    for (int i = 0; i < 4; i++) begin
      tick(pat[i]);
      n_checks++;
      if (bus.sig_out !== 1'b1) begin n_fail++; $display("FAIL bounce_hold_high edge %0d got %b exp 1", i, bus.sig_out); end
    end
    for (int i = 1; i <= int'(LAT + SC) + 3; i++) begin
      tick(1'b0);
      if (fall_at < 0 && bus.sig_out === 1'b0) fall_at = i;
      n_checks += 2;
      if (bus.sig_out !== m_out) begin n_fail++; $display("FAIL bounce_sig_out edge %0d got %b exp %b", i, bus.sig_out, m_out); end
      if (bus.glitch !== m_glitch) begin n_fail++; $display("FAIL bounce_glitch edge %0d got %b exp %b", i, bus.glitch, m_glitch); end
    end
    n_checks += 2;
    if (fall_at != int'(LAT + SC)) begin n_fail++; $display("FAIL bounce_fall_latency got %0d exp %0d", fall_at, LAT + SC); end
    if (int'(bus.glitch_cnt) != base + 2) begin n_fail++; $display("FAIL bounce_glitch_cnt got %0d exp %0d", bus.glitch_cnt, base + 2); end
  endtask

  task automatic test_rise();
    int pulses = 0;
    logic prev = 1'b0;
    for (int i = 1; i <= int'(LAT + SC) + 3; i++) begin
      tick(1'b1);
      if (bus.sig_out === 1'b1 && prev === 1'b0) pulses++;
      prev = bus.sig_out;
      n_checks += 2;
      if (bus.busy !== (i >= int'(LAT) + 1 && i < int'(LAT + SC))) begin
        n_fail++; $display("FAIL rise_busy edge %0d got %b exp %b", i, bus.busy, (i >= int'(LAT) + 1 && i < int'(LAT + SC)));
      end
      if (bus.sig_out !== (i >= int'(LAT + SC))) begin
        n_fail++; $display("FAIL rise_sig_out edge %0d got %b exp %b", i, bus.sig_out, i >= int'(LAT + SC));
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL rise_edge_count got %0d exp 1", pulses); end
  endtask

  task automatic test_glitch();
    int base;
    int pulses = 0;
    for (int i = 0; i < int'(LAT + SC) + 2; i++) tick(1'b0);
    n_checks++;
    if (bus.sig_out !== 1'b0) begin n_fail++; $display("FAIL glitch_pre_low got %b exp 0", bus.sig_out); end
    base = m_gcnt;
    tick(1'b1); tick(1'b1);
    for (int i = 0; i < int'(LAT + SC) + 2; i++) begin
      tick(1'b0);
      if (bus.glitch === 1'b1) pulses++;
      n_checks++;
      if (bus.sig_out !== 1'b0) begin n_fail++; $display("FAIL glitch_sig_out edge %0d got %b exp 0", i, bus.sig_out); end
    end
    n_checks += 3;
    if (pulses != 1) begin n_fail++; $display("FAIL glitch_pulse_count got %0d exp 1", pulses); end
    if (int'(bus.glitch_cnt) != base + 1) begin n_fail++; $display("FAIL glitch_cnt got %0d exp %0d", bus.glitch_cnt, base + 1); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    for (int i = 0; i < int'(LAT) + 2; i++) tick(1'b0);
    n_checks += 2;
    if (bus.glitch_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate_glitch_cnt got %0d exp 255", bus.glitch_cnt); end
    if (bus.sig_out !== 1'b0) begin n_fail++; $display("FAIL saturate_sig_out got %b exp 0", bus.sig_out); end
  endtask

  task automatic test_reset_mid();
    int rise_at = -1;
    for (int i = 0; i < int'(LAT) + 2; i++) tick(1'b1);
    n_checks += 2;
    if (m_run != 2) begin n_fail++; $display("FAIL mid_model_run got %0d exp 2", m_run); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy got %b exp 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks += 3;
    if (bus.sig_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sig_out got %b exp 0", bus.sig_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", bus.busy); end
    if (bus.glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_glitch_cnt got %0d exp 0", bus.glitch_cnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= int'(LAT + SC) + 2; i++) begin
      tick(1'b1);
      if (rise_at < 0 && bus.sig_out === 1'b1) rise_at = i;
    end
    n_checks++;
    if (rise_at != int'(LAT + SC)) begin n_fail++; $display("FAIL mid_rise_latency got %0d exp %0d", rise_at, LAT + SC); end
  endtask

  task automatic test_random();
    int cyc = 0;
    while (cyc < 600) begin
      logic v = 1'($urandom_range(0, 1));
      int len = int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++) begin
        tick(v);
        cyc++;
        n_checks += 4;
        if (bus.sig_out !== m_out) begin n_fail++; $display("FAIL rand_sig_out cyc %0d got %b exp %b", cyc, bus.sig_out, m_out); end
        if (bus.busy !== (m_run > 0)) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, bus.busy, m_run > 0); end
        if (bus.glitch !== m_glitch) begin n_fail++; $display("FAIL rand_glitch cyc %0d got %b exp %b", cyc, bus.glitch, m_glitch); end
        if (int'(bus.glitch_cnt) != m_gcnt) begin n_fail++; $display("FAIL rand_glitch_cnt cyc %0d got %0d exp %0d", cyc, bus.glitch_cnt, m_gcnt); end
      end
    end
  endtask

  initial begin
    bus.sig_in = 1'b0;
    test_reset();
    test_bounce_fall();
    test_rise();
    test_glitch();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sig_debounce.md
Name: sig_debounce

Overview:
Upstream conditioning stage for the positive-edge detector. Takes a raw, asynchronous, possibly bouncy level (button, external strobe) and produces a clean, glitch-free, clk-synchronous level on sig_out. sig_out connects directly to the edge detector's sig input. Also reports rejected glitches for diagnostics.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops ahead of the debounce FSM (>=2).
CNT_W, 16, width of the stability counter.
STABLE_CYCLES, 1000, consecutive identical synchronized samples needed to accept a new level (2 .. 2**CNT_W-1).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
sig_in  input  1  raw asynchronous level
sig_out  output  1  debounced, synchronous level (feeds edge detector sig)
busy  output  1  high while a candidate level change is being qualified
glitch  output  1  one-cycle pulse when a candidate change is abandoned
glitch_cnt  output  8  saturating count of glitch pulses since reset

Behaviour:
- Reset (async assert, sync to clk edge on release) values:
  - sig_out=0, busy=0, glitch=0, glitch_cnt=0.
  - Synchronizer flops=0, state=IDLE_LO, counter=0.
- s = synchronizer output (last of SYNC_STAGES flops). FSM samples s on each clk edge.
- States: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
- IDLE_LO:
  - s=1 -> CHK_HI, cnt<=1.
  - Otherwise hold.
- CHK_HI:
  - s=0 -> IDLE_LO, glitch<=1 for one cycle, cnt<=0.
  - s=1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, sig_out<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- IDLE_HI and CHK_LO: mirror of IDLE_LO and CHK_HI with polarities swapped; sig_out<=0 on acceptance.
- sig_out is registered and changes only on acceptance. It never toggles more than once per STABLE_CYCLES cycles, so each clean transition yields exactly one downstream edge.
- Latency: sig_out updates on the (SYNC_STAGES+STABLE_CYCLES)-th clk edge after the first edge that samples the new sig_in level, provided sig_in stays stable.
- busy = state is CHK_HI or CHK_LO (combinational from state register).
- glitch_cnt:
  - Increments on every glitch pulse.
  - Saturates at 255; no wrap.
- Abort on the final sample: the sample that would complete the count disagrees, so the change is a glitch and no acceptance occurs.
- Counter never exceeds STABLE_CYCLES-1; no wrap possible.
- Reset mid-qualification: the candidate is discarded and sig_out returns to 0. If sig_in is high after release, a full SYNC_STAGES+STABLE_CYCLES qualification is required.

Optional Feature:
SIG_DEBOUNCE_SYNC_EN
- Defined: the SYNC_STAGES-flop synchronizer is instantiated; latency is SYNC_STAGES+STABLE_CYCLES.
- Undefined: s=sig_in directly. Caller guarantees sig_in is clk-synchronous. Latency is STABLE_CYCLES; SYNC_STAGES is ignored.

Decomposition:
- Package sig_debounce_pkg:
  - FSM state enum (IDLE_LO, CHK_HI, IDLE_HI, CHK_LO).
  - Default CNT_W constant.
  - GLITCH_CNT_W=8 and its saturation value 255.
- Sub-module sig_sync: parameterized N-flop synchronizer with async active-high reset to 0. Instantiated only under SIG_DEBOUNCE_SYNC_EN.

Test Plan:
(STABLE_CYCLES=4, SYNC_STAGES=2, SIG_DEBOUNCE_SYNC_EN defined unless noted)
- Reset with sig_in=1 -> sig_out=0, busy=0, glitch=0, glitch_cnt=0 during reset; sig_out rises 6 edges after release.
- sig_in 0->1 held -> busy rises after edge 3; sig_out=1 after edge 6; downstream edge detector emits exactly one pulse.
- sig_in high for 2 cycles then low -> sig_out stays 0; one glitch pulse; glitch_cnt=1; state back to IDLE_LO.
- sig_out=1, then sig_in bounces 1-0-1-0 at 1-cycle spacing before settling 0 -> sig_out falls only 6 edges after the final settle; glitch_cnt increments once per aborted candidate.
- 300 consecutive 1-cycle glitches -> glitch_cnt saturates at 255 and stays there.
- rst asserted mid-CHK_HI (cnt=2) with sig_in=1 -> immediate sig_out=0, busy=0; after release sig_out=1 exactly 6 edges later.
- Build without SIG_DEBOUNCE_SYNC_EN, synchronous sig_in 0->1 -> sig_out=1 on the 4th edge sampling 1.
